// File: rtl/cnn_run_sequencer.sv
// cnn_run_sequencer
//   Configuration store and run controller for the 4x4 CNN array.
//   Holds the A/B templates, the 16 cell inputs U, the bias I and the
//   initial state, all written over a single-cycle write port. A run starts
//   the array (one INIT cycle), advances it once per clock while in RUN, and
//   finishes on convergence (all Y unchanged for STABLE_CYCLES consecutive
//   iterations) or when MAX_ITER iterations have been executed. The sign
//   image of Y is latched at completion.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_we/addr/wdata   config write: 0-8 A1..A9, 9-17 B1..B9, 18-33 U1..U16,
//                       34 I, 35 initial X (full 2*WIDTH); others ignored
//   start, abort        run request pulse / cancel (abort wins)
//   y_flat              Y1..Y16 from the array, Yk at [k*2W-1 -: 2W]
//   a_flat, b_flat,     template / input / bias / initial-state registers,
//   u_flat, i_out,      element k at [k*W-1 -: W]
//   x0_out
//   arr_init, arr_en    array control (INIT load, RUN advance)
//   busy, done          state decode (INIT|RUN, DONE)
//   converged, iter_cnt result of the current or last run
//   y_bin               bit k-1 = 1 when Yk is non-negative
//
// Handshake: no valid/ready; start and abort are level-sampled pulses on the
// rising edge, and done stays high until the next start or abort.

module cnn_run_sequencer #(
   parameter int WIDTH         = 9,
   parameter int ITER_W        = 16,
   parameter int MAX_ITER      = 1000,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [5:0]            cfg_addr,
   input  logic [2*WIDTH-1:0]    cfg_wdata,
   input  logic                  start,
   input  logic                  abort,
   input  logic [32*WIDTH-1:0]   y_flat,
   output logic [9*WIDTH-1:0]    a_flat,
   output logic [9*WIDTH-1:0]    b_flat,
   output logic [16*WIDTH-1:0]   u_flat,
   output logic [WIDTH-1:0]      i_out,
   output logic [2*WIDTH-1:0]    x0_out,
   output logic                  arr_init,
   output logic                  arr_en,
   output logic                  busy,
   output logic                  done,
   output logic                  converged,
   output logic [ITER_W-1:0]     iter_cnt,
   output logic [15:0]           y_bin
);

   typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0]    a_r [9];
   logic [WIDTH-1:0]    b_r [9];
   logic [WIDTH-1:0]    u_r [16];
   logic [WIDTH-1:0]    i_r;
   logic [2*WIDTH-1:0]  x0_r;

   logic [32*WIDTH-1:0] prev_y;
   logic                prev_valid;
   logic [ITER_W-1:0]   stable_cnt;
   logic [ITER_W-1:0]   stable_nx;
   logic [ITER_W-1:0]   iter_nx;
   logic                conv_hit;
   logic                lim_hit;
   logic                cfg_ok;
   logic [15:0]         y_sign;

   // Values a RUN cycle would commit; also used to decide completion on
   // the same edge.
   always_comb begin
      stable_nx = (prev_valid && (y_flat == prev_y)) ? stable_cnt + 1'b1 : '0;
      iter_nx   = iter_cnt + 1'b1;
      conv_hit  = (stable_nx == ITER_W'(STABLE_CYCLES));
      lim_hit   = (iter_nx == ITER_W'(MAX_ITER));
      cfg_ok    = cfg_we && ((state == IDLE) || (state == DONE));
      for (int k = 0; k < 16; k++) begin
         y_sign[k] = ~y_flat[(k+1)*2*WIDTH-1];
      end
   end

   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nx = INIT;
            INIT:    state_nx = RUN;
            RUN:     if (conv_hit || lim_hit) state_nx = DONE;
            DONE:    if (start) state_nx = INIT;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         i_r        <= '0;
         x0_r       <= '0;
         prev_y     <= '0;
         prev_valid <= 1'b0;
         stable_cnt <= '0;
         iter_cnt   <= '0;
         converged  <= 1'b0;
         y_bin      <= '0;
         for (int k = 0; k < 9; k++) begin
            a_r[k] <= '0;
            b_r[k] <= '0;
         end
         for (int k = 0; k < 16; k++) begin
            u_r[k] <= '0;
         end
      end else begin
         state <= state_nx;

         if (cfg_ok) begin
            for (int k = 0; k < 9; k++) begin
               if (cfg_addr == 6'(k))      a_r[k] <= cfg_wdata[WIDTH-1:0];
               if (cfg_addr == 6'(k + 9))  b_r[k] <= cfg_wdata[WIDTH-1:0];
            end
            for (int k = 0; k < 16; k++) begin
               if (cfg_addr == 6'(k + 18)) u_r[k] <= cfg_wdata[WIDTH-1:0];
            end
            if (cfg_addr == 6'd34) i_r  <= cfg_wdata[WIDTH-1:0];
            if (cfg_addr == 6'd35) x0_r <= cfg_wdata;
         end

         // An abort freezes the run results exactly as they stood.
         if (!abort) begin
            if (state == INIT) begin
               iter_cnt   <= '0;
               stable_cnt <= '0;
               prev_valid <= 1'b0;
               converged  <= 1'b0;
            end else if (state == RUN) begin
               iter_cnt   <= iter_nx;
               prev_y     <= y_flat;
               prev_valid <= 1'b1;
               stable_cnt <= stable_nx;
               if (conv_hit || lim_hit) begin
                  converged <= conv_hit;
                  y_bin     <= y_sign;
               end
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 9; k++) begin
         a_flat[k*WIDTH +: WIDTH] = a_r[k];
         b_flat[k*WIDTH +: WIDTH] = b_r[k];
      end
      for (int k = 0; k < 16; k++) begin
         u_flat[k*WIDTH +: WIDTH] = u_r[k];
      end
      i_out    = i_r;
      x0_out   = x0_r;
      arr_init = (state == INIT);
      arr_en   = (state == RUN);
      busy     = (state == INIT) || (state == RUN);
      done     = (state == DONE);
   end

endmodule

// File: doc/cnn_run_sequencer.md
# cnn_run_sequencer

Control and configuration front-end for the 4x4 cellular-neural-network array (`fourbyfour`). It holds the A/B templates, the 16 cell inputs U, the bias I and the initial state, all loaded over a simple write port. It then starts the array, advances it one iteration per clock, and detects convergence (all Y outputs unchanged for a programmable number of iterations) or timeout. On completion it latches a 16-bit binary result image. It replaces hard-wired template constants in the top level, so the same array can run different templates back to back.

## Interface
Parameters:
- `WIDTH`, 9, template/input word width; fixed point {sign, 2^3..2^-4}, so 0x010 = 1.0.
- `ITER_W`, 16, iteration counter width.
- `MAX_ITER`, 1000, iteration limit; 1 ≤ MAX_ITER < 2^ITER_W.
- `STABLE_CYCLES`, 3, consecutive unchanged iterations required to declare convergence; ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_addr`  in  6  0–8 A1..A9, 9–17 B1..B9, 18–33 U1..U16, 34 I, 35 Initial_X.
- `cfg_wdata`  in  2*WIDTH  write data; low WIDTH bits used except at addr 35.
- `start`  in  1  run request pulse.
- `abort`  in  1  cancel the run.
- `y_flat`  in  32*WIDTH  Y1..Y16 from the array, Yk at [k*2W-1 -: 2W].
- `a_flat`, `b_flat`  out  9*WIDTH each  template registers, element k at [k*W-1 -: W].
- `u_flat`  out  16*WIDTH  U registers.
- `i_out`  out  WIDTH  bias.
- `x0_out`  out  2*WIDTH  initial state.
- `arr_init`  out  1  array loads Initial_X this cycle.
- `arr_en`  out  1  array state advances this cycle.
- `busy`  out  1  high in INIT or RUN.
- `done`  out  1  high in DONE.
- `converged`  out  1  the last run ended by convergence.
- `iter_cnt`  out  ITER_W  RUN cycles executed in the current or last run.
- `y_bin`  out  16  bit k-1 = ~Yk[MSB] (1 = non-negative), captured at completion.

## Operation
- States: IDLE, INIT, RUN, DONE. `arr_init` = (state==INIT). `arr_en` = (state==RUN). `busy` and `done` are decoded from the state.
- Config writes are accepted only in IDLE or DONE. A write while busy is ignored. An address above 35 is ignored.
- IDLE/DONE + `start` → INIT. INIT clears `iter_cnt`, `stable_cnt` and `prev_valid`, and clears `converged`.
- INIT → RUN unconditionally after 1 cycle.
- Each RUN cycle performs all of the following:
  - `iter_cnt` += 1.
  - `prev_y` <= `y_flat`.
  - `prev_valid` <= 1.
  - `stable_cnt` <= (`prev_valid` && `y_flat`==`prev_y`) ? `stable_cnt`+1 : 0.
- Leave RUN → DONE when the new `stable_cnt` == STABLE_CYCLES (sets `converged`=1) or the new `iter_cnt` == MAX_ITER (`converged`=0).
  - If both happen on the same edge, convergence wins.
  - On that edge `y_bin` is captured from `y_flat`.
- DONE holds the results until `start` (new run) or `abort`.
- `abort` in any state → IDLE next cycle. Config registers are kept; `iter_cnt`, `y_bin` and `converged` are left unchanged. `abort` takes priority over `start` and over completion.
- `start` while busy is ignored.
- Equality is a full 32*WIDTH-bit compare; no tolerance.

## Timing
- Reset values:
  - State IDLE.
  - All config registers 0; all outputs 0.
  - `prev_y` 0, `stable_cnt` 0.
- `rst` mid-run: IDLE on the next edge, all config cleared.
- `start` sampled at edge t → INIT during t+1 → RUN from t+2.
- `y_flat` is sampled in the same cycle `arr_en` is high (the array output is registered).
- Minimum run length is STABLE_CYCLES+1 RUN cycles.
- `done` rises the cycle after the completing RUN cycle.
- A config write takes effect on the outputs 1 cycle after `cfg_we`.

## Test plan
- Config load: write addr 4 = 0x010, addr 13 = 0x040, addr 34 = 0x1B0, addr 35 = 0x00000 → `a_flat` A5 = 0x010, `b_flat` B5 = 0x040, `i_out` = 0x1B0. Then write addr 40 → no register changes.
- Convergence (STABLE_CYCLES=3), `y_flat` constant with Y6,7,10,11 positive and the rest negative, `start` at cycle 0:
  - INIT at cycle 1; RUN cycles 2–5 (`arr_en` high 4 cycles).
  - At cycle 6: `done`=1, `converged`=1, `iter_cnt`=4, `y_bin`=0x0660.
- Timeout (MAX_ITER=10), `y_flat` toggling every cycle → `done` after 10 RUN cycles, `converged`=0, `iter_cnt`=10.
- Simultaneous limit: MAX_ITER=4, STABLE_CYCLES=3, `y_flat` constant → `converged`=1 with `iter_cnt`=4.
- Abort and busy protection: `abort` at RUN cycle 3 → IDLE next cycle, `arr_en`=0, `done`=0. A `cfg_we` issued during RUN leaves the registers unchanged. `start` during RUN has no effect.
- Reset mid-run: `rst` in RUN → next cycle IDLE, every output 0. A new `start` after reset runs with zeroed templates.
